// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU codes, forward selects, multiplier FSM, EX/MEM layout.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ex_pkg;

    localparam int MUL_CYCLES = 32;
    localparam logic [4:0] MUL_CNT_LAST = 5'(MUL_CYCLES - 1);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] FWD_IDEX = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic [31:0] instr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  wr_reg;
    } exmem_t;

    // Select 11 is unused by the hazard unit and falls back to the ID/EX operand
    function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] idex,
                                            input logic [31:0] wb, input logic [31:0] mem);
        logic [31:0] v;
        case (sel)
            FWD_IDEX: v = idex;
            FWD_WB:   v = wb;
            FWD_MEM:  v = mem;
            default:  v = idex;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle, plus stall and redirect outputs.
// Latency: n/a (wiring only).
// Backpressure: oStall holds upstream stages; oTaken flushes them.
interface ex_stage_if;
    logic [31:0] iInstr;
    logic        iRegWrite, iALUSrc, iMemRead, iMemWrite, iMemToReg, iBranch, iJump;
    logic [3:0]  iALUCtrl;
    logic [31:0] iA, iB, ioutSignEXT, iNPC1;
    logic [4:0]  iwriteRegWire;
    logic [1:0]  iFwdA, iFwdB;
    logic [31:0] iMemFwd, iWbFwd;
    logic [31:0] oInstr;
    logic        oRegWrite, oMemRead, oMemWrite, oMemToReg;
    logic [31:0] oALUResult, oStoreData;
    logic [4:0]  owriteRegWire;
    logic        oStall, oTaken;
    logic [31:0] oTarget;

    // master: drives the ID/EX side (pipeline or bench); slave: the execute stage
    modport master (
        output iInstr, iRegWrite, iALUSrc, iMemRead, iMemWrite, iMemToReg, iBranch, iJump,
               iALUCtrl, iA, iB, ioutSignEXT, iNPC1, iwriteRegWire, iFwdA, iFwdB, iMemFwd, iWbFwd,
        input  oInstr, oRegWrite, oMemRead, oMemWrite, oMemToReg, oALUResult, oStoreData,
               owriteRegWire, oStall, oTaken, oTarget
    );
    modport slave (
        input  iInstr, iRegWrite, iALUSrc, iMemRead, iMemWrite, iMemToReg, iBranch, iJump,
               iALUCtrl, iA, iB, ioutSignEXT, iNPC1, iwriteRegWire, iFwdA, iFwdB, iMemFwd, iWbFwd,
        output oInstr, oRegWrite, oMemRead, oMemWrite, oMemToReg, oALUResult, oStoreData,
               owriteRegWire, oStall, oTaken, oTarget
    );
endinterface

// File: rtl/ex_stage_iter_mul.sv
// Iterative shift-add multiplier, one multiplier bit per enabled cycle, low 32 bits of product.
// Latency: start edge + MUL_CYCLES busy edges, then o_done for one enabled cycle.
// Backpressure: i_en=0 freezes all state; reset aborts to idle.
// Ports: clock/reset, i_en, i_start (sampled in idle), i_a/i_b operands, o_busy/o_done, o_prod.
module iter_mul
    import ex_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_en,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_prod
);
    mul_state_t  r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mcand  <= i_a;
                        r_mplier <= i_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 32'd0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == MUL_CNT_LAST) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == ST_BUSY);
    assign o_done = (r_state == ST_DONE);
    assign o_prod = r_acc;
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, iterative MUL, EX/MEM register.
// Latency: 1 edge for single-cycle ops; MUL result lands 34 enabled edges after entering EX.
// Backpressure: enable=0 freezes EX/MEM and the multiplier; oStall holds PC, IF/ID and ID/EX during MUL.
// Ports: clock, reset (sync, active-high), enable, bus (ex_stage_if.slave: ID/EX in, EX/MEM out).
module ex_stage
    import ex_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      enable,
    ex_stage_if.slave bus
);
    logic [31:0] w_opA, w_fwdB, w_opB, w_alu, w_prod;
    logic [31:0] w_br_target, w_jmp_target;
    logic        w_is_mul, w_zero, w_busy, w_done, w_idle, w_stall;
    exmem_t      w_next;
    exmem_t      r_exmem;

    assign w_opA  = fwd_sel(bus.iFwdA, bus.iA, bus.iWbFwd, bus.iMemFwd);
    assign w_fwdB = fwd_sel(bus.iFwdB, bus.iB, bus.iWbFwd, bus.iMemFwd);
    assign w_opB  = bus.iALUSrc ? bus.ioutSignEXT : w_fwdB;

    // MUL yields 0 here; its result comes from the iterative unit
    always_comb begin
        w_alu = '0;
        case (bus.iALUCtrl)
            ALU_AND: w_alu = w_opA & w_opB;
            ALU_OR:  w_alu = w_opA | w_opB;
            ALU_ADD: w_alu = w_opA + w_opB;
            ALU_SUB: w_alu = w_opA - w_opB;
            ALU_NOR: w_alu = ~(w_opA | w_opB);
            ALU_SLT: w_alu = ($signed(w_opA) < $signed(w_opB)) ? 32'd1 : 32'd0;
            default: w_alu = '0;
        endcase
    end

    assign w_is_mul = (bus.iALUCtrl == ALU_MUL);
    assign w_zero   = (w_alu == 32'd0) && !w_is_mul;
    assign w_idle   = !w_busy && !w_done;
    // Stall covers the launch cycle and every busy cycle; DONE lets ID/EX advance
    assign w_stall  = (w_idle && w_is_mul) || w_busy;

    iter_mul u_mul (
        .clock   (clock),
        .reset   (reset),
        .i_en    (enable),
        .i_start (w_is_mul),
        .i_a     (w_opA),
        .i_b     (w_opB),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_prod  (w_prod)
    );

    assign w_br_target  = bus.iNPC1 + {bus.ioutSignEXT[29:0], 2'b00};
    assign w_jmp_target = {bus.iNPC1[31:28], bus.iInstr[25:0], 2'b00};

    // The instruction presented while the multiplier runs is the held MUL, never a redirect
    assign bus.oTaken  = w_idle && ((bus.iBranch && w_zero) || bus.iJump);
    assign bus.oTarget = bus.iJump ? w_jmp_target : w_br_target;
    assign bus.oStall  = w_stall;

    always_comb begin
        w_next            = '0;
        w_next.instr      = bus.iInstr;
        w_next.reg_write  = bus.iRegWrite;
        w_next.mem_read   = bus.iMemRead;
        w_next.mem_write  = bus.iMemWrite;
        w_next.mem_to_reg = bus.iMemToReg;
        w_next.result     = w_done ? w_prod : w_alu;
        w_next.store_data = w_fwdB;
        w_next.wr_reg     = bus.iwriteRegWire;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_exmem <= '0;
        end else if (enable) begin
            r_exmem <= w_stall ? exmem_t'('0) : w_next;
        end
    end

    assign bus.oInstr        = r_exmem.instr;
    assign bus.oRegWrite     = r_exmem.reg_write;
    assign bus.oMemRead      = r_exmem.mem_read;
    assign bus.oMemWrite     = r_exmem.mem_write;
    assign bus.oMemToReg     = r_exmem.mem_to_reg;
    assign bus.oALUResult    = r_exmem.result;
    assign bus.oStoreData    = r_exmem.store_data;
    assign bus.owriteRegWire = r_exmem.wr_reg;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver queues expected stall/redirect and EX/MEM values per cycle,
// the monitor checks combinational outputs at the falling edge and EX/MEM after the rising edge.
module tb_ex_stage;
    import ex_pkg::*;

    logic clock = 1'b0;
    logic reset, enable;
    ex_stage_if bus ();

    ex_stage dut (.clock(clock), .reset(reset), .enable(enable), .bus(bus));

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] tag;
        logic        stall;
        logic        taken;
        logic [31:0] target;
        exmem_t      em;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    function automatic exmem_t em(input logic [31:0] instr, input logic rw, input logic mr,
                                  input logic mw, input logic m2r, input logic [31:0] res,
                                  input logic [31:0] sd, input logic [4:0] wr);
        exmem_t e;
        e.instr = instr; e.reg_write = rw; e.mem_read = mr; e.mem_write = mw; e.mem_to_reg = m2r;
        e.result = res; e.store_data = sd; e.wr_reg = wr;
        return e;
    endfunction

    // Monitor: comb outputs before the edge, EX/MEM after it
    initial begin
        exp_t   e;
        exmem_t a;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q[0];
                chk($sformatf("%s stall", e.tag), 128'(bus.oStall), 128'(e.stall));
                chk($sformatf("%s taken", e.tag), 128'(bus.oTaken), 128'(e.taken));
                if (e.taken)
                    chk($sformatf("%s target", e.tag), 128'(bus.oTarget), 128'(e.target));
                @(posedge clock);
                #2;
                a = em(bus.oInstr, bus.oRegWrite, bus.oMemRead, bus.oMemWrite, bus.oMemToReg,
                       bus.oALUResult, bus.oStoreData, bus.owriteRegWire);
                chk($sformatf("%s exmem", e.tag), 128'(a), 128'(e.em));
                void'(q.pop_front());
            end
        end
    end

    task automatic step(input logic [63:0] tag, input logic st, input logic tk,
                        input logic [31:0] tg, input exmem_t r);
        exp_t e;
        e.tag = tag; e.stall = st; e.taken = tk; e.target = tg; e.em = r;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic nop();
        bus.iInstr = '0; bus.iRegWrite = 0; bus.iALUSrc = 0; bus.iMemRead = 0; bus.iMemWrite = 0;
        bus.iMemToReg = 0; bus.iBranch = 0; bus.iJump = 0; bus.iALUCtrl = ALU_AND;
        bus.iA = '0; bus.iB = '0; bus.ioutSignEXT = '0; bus.iNPC1 = '0; bus.iwriteRegWire = '0;
        bus.iFwdA = 2'b00; bus.iFwdB = 2'b00; bus.iMemFwd = '0; bus.iWbFwd = '0;
        enable = 1'b1; reset = 1'b0;
    endtask

    task automatic alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] instr, input logic [4:0] wr);
        nop();
        bus.iALUCtrl = ctrl; bus.iA = a; bus.iB = b; bus.iInstr = instr;
        bus.iwriteRegWire = wr; bus.iRegWrite = 1'b1;
    endtask

    // MUL with optional 5-style enable gap starting at cycle 10; operands scrambled mid-run
    task automatic run_mul(input logic [63:0] tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] instr, input logic rw, input logic [4:0] wr,
                           input int dl, input logic [31:0] res);
        nop();
        bus.iALUCtrl = ALU_MUL; bus.iB = b; bus.iInstr = instr; bus.iRegWrite = rw;
        bus.iwriteRegWire = wr;
        for (int k = 0; k <= 33 + dl; k++) begin
            enable    = !(k >= 10 && k < 10 + dl);
            bus.iA    = (k >= 2 && k < 8) ? 32'h1357_9BDF : a;
            bus.iJump = (k > 0 && k < 33 + dl);
            if (k == 33 + dl) step(tag, 1'b0, 1'b0, '0, em(instr, rw, 0, 0, 0, res, b, wr));
            else              step(tag, 1'b1, 1'b0, '0, '0);
        end
        nop();
        step("postmul", 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        nop();
        bus.iALUCtrl = ALU_ADD; bus.iA = 5; bus.iB = 7; bus.iRegWrite = 1; bus.iInstr = 32'h1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        step("reset", 1'b0, 1'b0, '0, '0);

        alu(ALU_ADD, 5, 7, 32'h00a7_4020, 5'd8);
        step("add", 1'b0, 1'b0, '0, em(32'h00a7_4020, 1, 0, 0, 0, 12, 7, 8));

        alu(ALU_SUB, 50, 1, 32'h0000_0bad, 5'd4);
        enable = 1'b0;
        step("hold", 1'b0, 1'b0, '0, em(32'h00a7_4020, 1, 0, 0, 0, 12, 7, 8));

        alu(ALU_SUB, 32'hdead, 1, 32'h0022_1822, 5'd3);
        bus.iFwdA = 2'b10; bus.iMemFwd = 100;
        step("fwdmem", 1'b0, 1'b0, '0, em(32'h0022_1822, 1, 0, 0, 0, 99, 1, 3));

        alu(ALU_ADD, 32'h100, 32'h55, 32'hac03_0008, 5'd3);
        bus.iRegWrite = 0; bus.iMemWrite = 1; bus.iALUSrc = 1; bus.ioutSignEXT = 8;
        bus.iFwdB = 2'b01; bus.iWbFwd = 3;
        step("store", 1'b0, 1'b0, '0, em(32'hac03_0008, 0, 0, 1, 0, 32'h108, 3, 3));

        alu(ALU_ADD, 4, 6, 32'h2, 5'd5);
        bus.iFwdA = 2'b11; bus.iFwdB = 2'b11; bus.iMemFwd = 100; bus.iWbFwd = 200;
        step("fwd11", 1'b0, 1'b0, '0, em(32'h2, 1, 0, 0, 0, 10, 6, 5));

        alu(ALU_SLT, 32'hffff_ffff, 1, 32'h3, 5'd6);
        step("slt", 1'b0, 1'b0, '0, em(32'h3, 1, 0, 0, 0, 1, 1, 6));

        alu(ALU_NOR, 32'h0f0f_0000, 32'h00ff_0000, 32'h4, 5'd7);
        step("nor", 1'b0, 1'b0, '0, em(32'h4, 1, 0, 0, 0, 32'hf000_ffff, 32'h00ff_0000, 7));

        alu(ALU_AND, 32'hff00_ff00, 32'h0ff0_0ff0, 32'h5, 5'd9);
        step("and", 1'b0, 1'b0, '0, em(32'h5, 1, 0, 0, 0, 32'h0f00_0f00, 32'h0ff0_0ff0, 9));

        alu(4'b0011, 5, 7, 32'h6, 5'd10);
        step("badop", 1'b0, 1'b0, '0, em(32'h6, 1, 0, 0, 0, 0, 7, 10));

        alu(ALU_SUB, 9, 9, 32'h1129_fffe, 5'd0);
        bus.iRegWrite = 0; bus.iBranch = 1; bus.ioutSignEXT = 32'hffff_fffe; bus.iNPC1 = 32'h40;
        step("beq_t", 1'b0, 1'b1, 32'h38, em(32'h1129_fffe, 0, 0, 0, 0, 0, 9, 0));

        bus.iA = 1;
        step("beq_nt", 1'b0, 1'b0, '0, em(32'h1129_fffe, 0, 0, 0, 0, 32'hffff_fff8, 9, 0));

        bus.iA = 9; bus.iJump = 1; bus.iNPC1 = 32'h3000_0040; bus.iInstr = 32'h0800_0123;
        step("jump", 1'b0, 1'b1, 32'h3000_048c, em(32'h0800_0123, 0, 0, 0, 0, 0, 9, 0));

        run_mul("mul1", 32'hffff_ffff, 3, 32'h0043_0018, 1'b1, 5'd2, 0, 32'hffff_fffd);
        run_mul("mul2", 32'h0001_0000, 32'h0001_0000, 32'h0108_4018, 1'b1, 5'd8, 0, 32'h0);
        run_mul("mulen", 32'hffff_ffff, 3, 32'h0043_0018, 1'b0, 5'd2, 5, 32'hffff_fffd);

        // Reset while BUSY with cnt=10: abort, nothing ever written
        nop();
        bus.iALUCtrl = ALU_MUL; bus.iA = 7; bus.iB = 9; bus.iRegWrite = 1; bus.iwriteRegWire = 5'd1;
        for (int k = 0; k <= 10; k++) step("mulrst", 1'b1, 1'b0, '0, '0);
        nop();
        reset = 1'b1;
        step("rstbusy", 1'b1, 1'b0, '0, '0);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) step("aftrst", 1'b0, 1'b0, '0, '0);

        alu(ALU_OR, 32'h00f0, 32'h0f00, 32'h7, 5'd11);
        step("or", 1'b0, 1'b0, '0, em(32'h7, 1, 0, 0, 0, 32'h0ff0, 32'h0f00, 11));

        repeat (3) @(posedge clock);
        #5;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0 entries left", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
